// File: rtl/libv_deque_frontend.sv
// Command front end for libv_deque: gates push/pop on locally tracked occupancy, registers pop
// responses, and drains the deque on flush. Optional high-water mark: LIBV_DEQUE_FRONTEND_HWM_EN.

package libv_deque_pkg;
  typedef enum logic [1:0] {
    PushFront = 2'd0,
    PopFront  = 2'd1,
    PushBack  = 2'd2,
    PopBack   = 2'd3
  } cmd_t;
endpackage

// state | meaning
// IDLE  | accept requests from the in port, forward them to the deque
// FLUSH | requests blocked; one PopBack per cycle until occupancy is zero
module libv_deque_frontend
  import libv_deque_pkg::*;
#(
  parameter  int W  = 32,
  parameter  int N  = 8,
  localparam int OW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_vld,
  input  cmd_t          in_op,
  input  logic [W-1:0]  in_data,
  output logic          in_rdy,
  input  logic          flush,
  output logic          busy,
  output logic          deq_cmd_vld,
  output cmd_t          deq_cmd_op,
  output logic [W-1:0]  deq_push_data,
  input  logic [W-1:0]  deq_pop_data,
  output logic          rsp_vld,
  output logic [W-1:0]  rsp_data,
  input  logic          rsp_rdy,
  output logic [OW-1:0] occ,
  output logic [OW-1:0] hwm
);

  typedef enum logic {IDLE = 1'b0, FLUSH = 1'b1} state_t;

  localparam logic [OW-1:0] OCC_FULL = OW'(N);

  state_t        state_q;
  logic [OW-1:0] occ_q, occ_d;
  logic          rsp_vld_q;
  logic [W-1:0]  rsp_data_q;

  logic is_push, rsp_free;
  logic push_acc, pop_cap, pop_iss;
  logic flushing;

  always_comb begin
    is_push     = (in_op == PushFront) || (in_op == PushBack);
    rsp_free    = !rsp_vld_q || rsp_rdy;
    in_rdy      = 1'b0;
    deq_cmd_vld = 1'b0;
    deq_cmd_op  = in_op;
    push_acc    = 1'b0;
    pop_cap     = 1'b0;
    pop_iss     = 1'b0;
    // rst_n gating keeps the deque port quiet for the whole reset window
    if (rst_n) begin
      case (state_q)
        IDLE: begin
          in_rdy      = !flush && (is_push ? (occ_q < OCC_FULL)
                                           : ((occ_q != '0) && rsp_free));
          deq_cmd_vld = in_vld && in_rdy;
          push_acc    = deq_cmd_vld && is_push;
          pop_cap     = deq_cmd_vld && !is_push;
          pop_iss     = pop_cap;
        end
        FLUSH: begin
          deq_cmd_op  = PopBack;
          deq_cmd_vld = (occ_q != '0);
          pop_iss     = deq_cmd_vld;
        end
        default: ;
      endcase
    end
    occ_d    = occ_q + {{(OW-1){1'b0}}, push_acc} - {{(OW-1){1'b0}}, pop_iss};
    flushing = (state_q == FLUSH) || flush;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      occ_q      <= '0;
      rsp_vld_q  <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      occ_q <= occ_d;
      case (state_q)
        IDLE:    if (flush) state_q <= FLUSH;
        FLUSH:   if (occ_q == '0) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      if (pop_cap) begin
        rsp_vld_q  <= 1'b1;
        rsp_data_q <= deq_pop_data;
      end else if (rsp_rdy) begin
        rsp_vld_q  <= 1'b0;
      end
    end
  end

  assign busy          = (state_q == FLUSH);
  assign deq_push_data = in_data;
  assign rsp_vld       = rsp_vld_q;
  assign rsp_data      = rsp_data_q;
  assign occ           = occ_q;

`ifdef LIBV_DEQUE_FRONTEND_HWM_EN
  logic [OW-1:0] hwm_q;

  // Held at zero for the whole drain so a completed flush leaves a clean mark.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hwm_q <= '0;
    end else if (flushing) begin
      hwm_q <= '0;
    end else if (occ_d > hwm_q) begin
      hwm_q <= occ_d;
    end
  end

  assign hwm = hwm_q;
`else
  logic unused_flushing;
  assign unused_flushing = flushing;
  assign hwm             = '0;
`endif

endmodule
